// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, state enum and transfer ROM for the HD44780 driver
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_OFF = 8'h08;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;

  localparam int NUM_CMDS = 7;
  localparam int MSG_LEN  = 14;
  localparam int ROM_LEN  = NUM_CMDS + MSG_LEN;

  typedef enum logic [2:0] {
    ST_PWR,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT,
    ST_DONE
  } lcd_state_t;

  // {RS, DB}: init commands first, then "SEJF ZAMKNIETY" as data
  function automatic logic [8:0] rom_entry(input logic [4:0] idx);
    logic [8:0] w;
    case (idx)
      5'd0, 5'd1, 5'd2: w = {1'b0, CMD_FUNC_SET};
      5'd3:  w = {1'b0, CMD_DISP_OFF};
      5'd4:  w = {1'b0, CMD_CLEAR};
      5'd5:  w = {1'b0, CMD_ENTRY};
      5'd6:  w = {1'b0, CMD_DISP_ON};
      5'd7:  w = {1'b1, 8'h53};
      5'd8:  w = {1'b1, 8'h45};
      5'd9:  w = {1'b1, 8'h4A};
      5'd10: w = {1'b1, 8'h46};
      5'd11: w = {1'b1, 8'h20};
      5'd12: w = {1'b1, 8'h5A};
      5'd13: w = {1'b1, 8'h41};
      5'd14: w = {1'b1, 8'h4D};
      5'd15: w = {1'b1, 8'h4B};
      5'd16: w = {1'b1, 8'h4E};
      5'd17: w = {1'b1, 8'h49};
      5'd18: w = {1'b1, 8'h45};
      5'd19: w = {1'b1, 8'h54};
      5'd20: w = {1'b1, 8'h59};
      default: w = 9'h000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// rtl/lcd_byte_writer.sv - SETUP/PULSE/HOLD/WAIT handshake for one {RS, DB} transfer
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int CLEAR_EXTRA_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rs_in,
  input  logic [7:0] db_in,
  output logic       e,
  output logic       rs,
  output logic [7:0] db,
  output logic       done
);

  lcd_state_t st;
  logic [7:0] wait_cnt;

  // done marks the final WAIT clock so the next start lands back-to-back
  assign done = (st == ST_WAIT) && (wait_cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= ST_DONE;
      e        <= 1'b0;
      rs       <= 1'b0;
      db       <= 8'h00;
      wait_cnt <= 8'd0;
    end else if (start) begin
      st <= ST_SETUP;
      e  <= 1'b0;
      rs <= rs_in;
      db <= db_in;
    end else begin
      case (st)
        ST_SETUP: begin
          e  <= 1'b1;
          st <= ST_PULSE;
        end
        ST_PULSE: begin
          e  <= 1'b0;
          st <= ST_HOLD;
        end
        ST_HOLD: begin
          st       <= ST_WAIT;
          wait_cnt <= (!rs && db == CMD_CLEAR) ? 8'(CLEAR_EXTRA_WAIT) : 8'd0;
        end
        ST_WAIT: begin
          if (wait_cnt == 8'd0) begin
            st <= ST_DONE;
            rs <= 1'b0;
            db <= 8'h00;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lcd_top.sv
// rtl/lcd_top.sv - power-up wait and ROM sequencing around the LCD byte writer
module lcd_top
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYCLES   = 20,
  parameter int CLEAR_EXTRA_WAIT = 2
) (
  input  logic       clk_1ms,
  input  logic       reset,
  output logic       E,
  output logic       RW,
  output logic       RS,
  output logic [7:0] DB
);

  localparam logic [4:0] LAST_IDX = 5'(ROM_LEN - 1);

  lcd_state_t st;
  logic [15:0] pwr_cnt;
  logic [4:0]  idx;
  logic [4:0]  load_idx;
  logic [8:0]  rom_word;
  logic        wr_start;
  logic        wr_done;

  // load the next entry on the same edge that ends the previous WAIT
  assign load_idx = (st == ST_PWR) ? 5'd0 : idx + 5'd1;
  assign rom_word = rom_entry(load_idx);
  assign wr_start = (st == ST_PWR && pwr_cnt == 16'(POWERUP_CYCLES)) ||
                    (st == ST_SETUP && wr_done && idx != LAST_IDX);
  assign RW       = 1'b0;

  always_ff @(posedge clk_1ms) begin
    if (reset) begin
      st      <= ST_PWR;
      pwr_cnt <= 16'd0;
      idx     <= 5'd0;
    end else begin
      case (st)
        ST_PWR: begin
          if (pwr_cnt == 16'(POWERUP_CYCLES)) begin
            st  <= ST_SETUP;
            idx <= 5'd0;
          end else begin
            pwr_cnt <= pwr_cnt + 16'd1;
          end
        end
        ST_SETUP: begin
          if (wr_done) begin
            if (idx == LAST_IDX) st <= ST_DONE;
            else                 idx <= idx + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  lcd_byte_writer #(
    .CLEAR_EXTRA_WAIT(CLEAR_EXTRA_WAIT)
  ) u_writer (
    .clk   (clk_1ms),
    .reset (reset),
    .start (wr_start),
    .rs_in (rom_word[8]),
    .db_in (rom_word[7:0]),
    .e     (E),
    .rs    (RS),
    .db    (DB),
    .done  (wr_done)
  );

endmodule

// File: tb/tb_lcd_top.sv
// tb/tb_lcd_top.sv - directed self-checking bench for lcd_top
module tb_lcd_top;

  logic       clk_1ms = 1'b0;
  logic       reset;
  logic       E, RW, RS;
  logic [7:0] DB;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp_rom [21];
  logic [8:0] got_word [21];
  int         rise_edge [21];
  int         n_rise;
  int         n_fall;

  lcd_top dut (
    .clk_1ms (clk_1ms),
    .reset   (reset),
    .E       (E),
    .RW      (RW),
    .RS      (RS),
    .DB      (DB)
  );

  always #5 clk_1ms = ~clk_1ms;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_1ms);
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      step();
      chk("rst_idle", {23'd0, E, RW, RS, DB}, 32'd0);
    end
    reset = 1'b0;
  endtask

  // runs edges 1..last_n after reset release, collecting E pulses and checking bus rules
  task automatic run(input int last_n);
    logic       prev_e = 1'b0;
    logic [8:0] prev_w = 9'h000;
    n_rise = 0;
    n_fall = 0;
    for (int n = 1; n <= last_n; n++) begin
      step();
      chk("rw_low", {31'd0, RW}, 32'd0);
      if (n <= 20) chk("pwr_idle", {23'd0, E, RS, DB}, 32'd0);
      if (n == 21) chk("first_setup", {23'd0, E, RS, DB}, {23'd0, 1'b0, 1'b0, 8'h38});
      if (n == 22) chk("first_pulse", {31'd0, E}, 32'd1);
      if (n == 23) chk("first_hold", {31'd0, E}, 32'd0);
      if (n == 106) chk("last_wait", {23'd0, E, RS, DB}, {23'd0, 1'b0, 1'b1, 8'h59});
      if (n >= 107) chk("done_idle", {23'd0, E, RS, DB}, 32'd0);
      if (E || prev_e) chk("stable", {23'd0, RS, DB}, {23'd0, prev_w});
      if (E && !prev_e) begin
        if (n_rise < 21) rise_edge[n_rise] = n;
        n_rise++;
      end
      if (!E && prev_e) begin
        if (n_fall < 21) got_word[n_fall] = {RS, DB};
        n_fall++;
      end
      prev_e = E;
      prev_w = {RS, DB};
    end
  endtask

  task automatic check_sequence();
    chk("pulse_count", n_rise, 21);
    chk("fall_count", n_fall, 21);
    for (int k = 0; k < 21; k++) begin
      chk($sformatf("word%0d", k), {23'd0, got_word[k]}, {23'd0, exp_rom[k]});
      chk($sformatf("rise%0d", k), rise_edge[k], 22 + 4 * k + ((k >= 5) ? 2 : 0));
    end
  endtask

  initial begin
    exp_rom = '{9'h038, 9'h038, 9'h038, 9'h008, 9'h001, 9'h006, 9'h00C,
                9'h153, 9'h145, 9'h14A, 9'h146, 9'h120, 9'h15A, 9'h141,
                9'h14D, 9'h14B, 9'h14E, 9'h149, 9'h145, 9'h154, 9'h159};
    reset = 1'b1;

    apply_reset(1);
    run(307);
    check_sequence();

    // interrupt the 5th data byte (entry 11, 0x20) while E is high
    apply_reset(1);
    run(68);
    chk("mid_pulse_e", {31'd0, E}, 32'd1);
    chk("mid_pulse_db", {24'd0, DB}, 32'h20);
    apply_reset(3);

    run(307);
    check_sequence();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
